// File: rtl/led_pkg.sv
// Shared definitions for the multi-channel LED blinker: mode encodings,
// field widths and small helpers used by the per-channel logic.
package led_pkg;

  // Field widths of the configuration port.
  localparam int HALF_W  = 16;
  localparam int COUNT_W = 8;
  localparam int CH_W    = 3;

  // Channel operating modes, encoded as written on the configuration port.
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  // A zero half-period would never terminate a count; treat it as 1 ms.
  function automatic logic [HALF_W-1:0] eff_half(input logic [HALF_W-1:0] half);
    return (half == '0) ? HALF_W'(1) : half;
  endfunction

  // Modes in which the channel follows the 1 ms tick and reports busy.
  function automatic logic is_timed(input mode_e mode);
    return (mode == MODE_BLINK) || (mode == MODE_BURST);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle strobe at TICK_HZ from CLK_HZ.
// The strobe is a decode of the counter's last value, so it is high for
// exactly one cycle per period and is low throughout reset.
module tick_gen #(
  parameter int CLK_HZ  = 12000000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  // A divide ratio below 2 would make the strobe constant; clamp it.
  localparam int DIV   = (CLK_HZ / TICK_HZ < 2) ? 2 : CLK_HZ / TICK_HZ;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: wrap from DIV-1 back to zero.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  // Prescaler register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/led_blinker_multi.sv
// Multi-channel LED driver. Each channel is configured at run time through a
// one-cycle write port and runs OFF, ON, continuous BLINK or a counted BURST,
// timed by a shared 1 ms tick. LED pins are registered and polarity-adjusted.
module led_blinker_multi
  import led_pkg::*;
#(
  parameter int CLK_HZ         = 12000000,
  parameter int NUM_CH         = 3,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cfg_we_i,
  input  logic [CH_W-1:0]     cfg_ch_i,
  input  logic [1:0]          cfg_mode_i,
  input  logic [HALF_W-1:0]   cfg_half_ms_i,
  input  logic [COUNT_W-1:0]  cfg_count_i,
  output logic [NUM_CH-1:0]   led_o,
  output logic [NUM_CH-1:0]   busy_o,
  output logic                tick_o
);

  logic tick_w;

  // Shared 1 ms time base; the tick period in clocks is CLK_HZ/1000.
  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (1000)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tick_o (tick_w)
  );

  assign tick_o = tick_w;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    mode_e              mode_q, mode_d;
    logic [HALF_W-1:0]  half_q, half_d;
    logic [HALF_W-1:0]  ms_cnt_q, ms_cnt_d;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic               lit_q, lit_d;
    logic               led_q;
    logic               sel;

    // A write addressed to this channel; out-of-range indices match nothing.
    assign sel = cfg_we_i && (cfg_ch_i == CH_W'(gi));

    // Next state: a write reloads the channel and swallows a coincident
    // tick; otherwise timed modes advance the ms counter on each tick.
    always_comb begin
      mode_d   = mode_q;
      half_d   = half_q;
      ms_cnt_d = ms_cnt_q;
      rem_d    = rem_q;
      lit_d    = lit_q;

      if (sel) begin
        ms_cnt_d = '0;
        half_d   = eff_half(cfg_half_ms_i);
        rem_d    = '0;
        case (mode_e'(cfg_mode_i))
          MODE_OFF: begin
            mode_d = MODE_OFF;
            lit_d  = 1'b0;
          end
          MODE_ON: begin
            mode_d = MODE_ON;
            lit_d  = 1'b1;
          end
          MODE_BLINK: begin
            mode_d = MODE_BLINK;
            lit_d  = 1'b1;
          end
          MODE_BURST: begin
            if (cfg_count_i == '0) begin
              // An empty burst never starts.
              mode_d = MODE_OFF;
              lit_d  = 1'b0;
            end else begin
              mode_d = MODE_BURST;
              lit_d  = 1'b1;
              rem_d  = cfg_count_i;
            end
          end
          default: begin
            mode_d = MODE_OFF;
            lit_d  = 1'b0;
          end
        endcase
      end else if (tick_w && is_timed(mode_q)) begin
        if (ms_cnt_q == half_q - 1'b1) begin
          ms_cnt_d = '0;
          lit_d    = ~lit_q;
          // A burst counts its lit->unlit transitions and stops on the last.
          if ((mode_q == MODE_BURST) && lit_q) begin
            if (rem_q <= COUNT_W'(1)) begin
              mode_d = MODE_OFF;
              lit_d  = 1'b0;
              rem_d  = '0;
            end else begin
              rem_d = rem_q - 1'b1;
            end
          end
        end else begin
          ms_cnt_d = ms_cnt_q + 1'b1;
        end
      end
    end

    // Channel state and registered pin drive; reset leaves every LED unlit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        mode_q   <= MODE_OFF;
        half_q   <= HALF_W'(1);
        ms_cnt_q <= '0;
        rem_q    <= '0;
        lit_q    <= 1'b0;
        led_q    <= LED_ACTIVE_LOW;
      end else begin
        mode_q   <= mode_d;
        half_q   <= half_d;
        ms_cnt_q <= ms_cnt_d;
        rem_q    <= rem_d;
        lit_q    <= lit_d;
        led_q    <= lit_q ^ LED_ACTIVE_LOW;
      end
    end

    assign led_o[gi]  = led_q;
    assign busy_o[gi] = is_timed(mode_q);
  end

endmodule

// File: tb/tb_led_blinker_multi.sv
// Scoreboard bench for led_blinker_multi at CLK_HZ=12000 (12 clocks per tick).
// Stimulus pushes the expected {cycle, LED, BUSY} of every output change;
// the monitor pops one entry per observed change and compares.
module tb_led_blinker_multi;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        we    = 1'b0;
  logic [2:0]  ch    = '0;
  logic [1:0]  mode  = '0;
  logic [15:0] half  = '0;
  logic [7:0]  count = '0;
  logic [2:0]  led;
  logic [2:0]  busy;
  logic        tick;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [2:0] led;
    logic [2:0] busy;
  } exp_t;

  exp_t exp_q[$];

  led_blinker_multi #(
    .CLK_HZ         (12000),
    .NUM_CH         (3),
    .LED_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cfg_we_i      (we),
    .cfg_ch_i      (ch),
    .cfg_mode_i    (mode),
    .cfg_half_ms_i (half),
    .cfg_count_i   (count),
    .led_o         (led),
    .busy_o        (busy),
    .tick_o        (tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int c, input logic [2:0] l, input logic [2:0] b);
    exp_t e;
    e.cyc  = c;
    e.led  = l;
    e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  // Monitor: every change of {LED, BUSY} must match the head of the queue.
  initial begin
    logic [5:0] prev;
    exp_t       e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev = {led, busy};
      end else if ({led, busy} != prev) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got led=%b busy=%b at cycle %0d, required no change",
                   led, busy, cyc);
        end else begin
          e = exp_q.pop_front();
          if (led !== e.led || busy !== e.busy || (e.cyc >= 0 && e.cyc != cyc)) begin
            n_bad++;
            $display("FAIL event: got led=%b busy=%b at cycle %0d, required led=%b busy=%b at cycle %0d",
                     led, busy, cyc, e.led, e.busy, e.cyc);
          end else begin
            $display("event cycle=%0d led=%b busy=%b ok", cyc, led, busy);
          end
        end
        prev = {led, busy};
      end
    end
  end

  // Advance to the next negedge at which TICK is high (bounded).
  task automatic sync_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 100);
    if (!tick) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tick_timeout: got no tick in %0d cycles, required one within 12", n);
    end
  endtask

  // Position for a write: collide=1 writes on the tick edge, otherwise on
  // the edge right after it. c0 is cyc now; the write lands at edge c0+1.
  task automatic align(input bit collide, output int c0);
    sync_tick();
    if (!collide) @(negedge clk);
    c0 = cyc;
  endtask

  task automatic do_write(input logic [2:0] c, input logic [1:0] m,
                          input logic [15:0] h, input logic [7:0] n);
    ch    = c;
    mode  = m;
    half  = h;
    count = n;
    we    = 1'b1;
    $display("write cycle=%0d ch=%0d mode=%0d half=%0d count=%0d", cyc + 1, c, m, h, n);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Negedges from now until TICK is seen high (bounded).
  task automatic count_to_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, c1, c2, n;

    // Reset
    #2 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_led", led, 3'b111);
    chk("reset_busy", busy, 0);
    chk("reset_tick", tick, 0);
    rst_n = 1'b1;
    count_to_tick(n);
    chk("first_tick", n, 11);
    count_to_tick(n);
    chk("tick_period_a", n, 12);
    count_to_tick(n);
    chk("tick_period_b", n, 12);
    mon_en = 1'b1;

    // BLINK ch0, half 3
    align(1'b0, c0);
    expect_ev(c0 + 1,   3'b111, 3'b001);
    expect_ev(c0 + 2,   3'b110, 3'b001);
    expect_ev(c0 + 37,  3'b111, 3'b001);
    expect_ev(c0 + 73,  3'b110, 3'b001);
    expect_ev(c0 + 109, 3'b111, 3'b001);
    do_write(3'd0, 2'd2, 16'd3, 8'd0);
    wait_until(c0 + 110);
    align(1'b0, c1);
    chk("blink_no_early_toggle", c1, c0 + 120);
    expect_ev(c1 + 1, 3'b111, 3'b000);
    do_write(3'd0, 2'd0, 16'd3, 8'd0);
    wait_until(c1 + 30);
    chk("blink_drain", exp_q.size(), 0);

    // BURST ch1, half 2, count 3
    align(1'b0, c0);
    expect_ev(c0 + 1,   3'b111, 3'b010);
    expect_ev(c0 + 2,   3'b101, 3'b010);
    expect_ev(c0 + 25,  3'b111, 3'b010);
    expect_ev(c0 + 49,  3'b101, 3'b010);
    expect_ev(c0 + 73,  3'b111, 3'b010);
    expect_ev(c0 + 97,  3'b101, 3'b010);
    expect_ev(c0 + 120, 3'b101, 3'b000);
    expect_ev(c0 + 121, 3'b111, 3'b000);
    do_write(3'd1, 2'd3, 16'd2, 8'd3);
    wait_until(c0 + 180);
    chk("burst_drain", exp_q.size(), 0);

    // BURST with count 0 on ch2: no change at all
    align(1'b0, c0);
    do_write(3'd2, 2'd3, 16'd5, 8'd0);
    wait_until(c0 + 60);
    chk("burst0_drain", exp_q.size(), 0);

    // half 0 on ch2 behaves as half 1
    align(1'b0, c0);
    expect_ev(c0 + 1,  3'b111, 3'b100);
    expect_ev(c0 + 2,  3'b011, 3'b100);
    expect_ev(c0 + 13, 3'b111, 3'b100);
    expect_ev(c0 + 25, 3'b011, 3'b100);
    do_write(3'd2, 2'd2, 16'd0, 8'd0);
    wait_until(c0 + 26);
    align(1'b0, c1);
    expect_ev(c1 + 1, 3'b111, 3'b000);
    do_write(3'd2, 2'd0, 16'd1, 8'd0);
    wait_until(c1 + 40);
    chk("half0_drain", exp_q.size(), 0);

    // Out-of-range channel index
    align(1'b0, c0);
    do_write(3'd5, 2'd1, 16'd1, 8'd0);
    wait_until(c0 + 40);
    chk("badch_drain", exp_q.size(), 0);

    // Write ch0 on a tick edge: the tick is discarded
    align(1'b1, c0);
    expect_ev(c0 + 1,  3'b111, 3'b001);
    expect_ev(c0 + 2,  3'b110, 3'b001);
    expect_ev(c0 + 14, 3'b111, 3'b001);
    expect_ev(c0 + 26, 3'b110, 3'b001);
    do_write(3'd0, 2'd2, 16'd1, 8'd0);
    wait_until(c0 + 27);
    align(1'b1, c1);
    expect_ev(c1 + 1, 3'b110, 3'b000);
    expect_ev(c1 + 2, 3'b111, 3'b000);
    do_write(3'd0, 2'd0, 16'd1, 8'd0);
    wait_until(c1 + 40);
    chk("collide_drain", exp_q.size(), 0);

    // Rewrite ch1 to ON mid-burst
    align(1'b0, c0);
    expect_ev(c0 + 1,  3'b111, 3'b010);
    expect_ev(c0 + 2,  3'b101, 3'b010);
    expect_ev(c0 + 25, 3'b111, 3'b010);
    do_write(3'd1, 2'd3, 16'd2, 8'd3);
    wait_until(c0 + 30);
    align(1'b0, c1);
    expect_ev(c1 + 1, 3'b111, 3'b000);
    expect_ev(c1 + 2, 3'b101, 3'b000);
    do_write(3'd1, 2'd1, 16'd2, 8'd0);
    wait_until(c1 + 40);
    chk("restart_drain", exp_q.size(), 0);

    // Restart a burst from ON, then reset mid-burst
    align(1'b0, c2);
    expect_ev(c2 + 1,  3'b101, 3'b010);
    expect_ev(c2 + 25, 3'b111, 3'b010);
    expect_ev(c2 + 49, 3'b101, 3'b010);
    do_write(3'd1, 2'd3, 16'd2, 8'd3);
    wait_until(c2 + 55);
    expect_ev(-1, 3'b111, 3'b000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_led", led, 3'b111);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_tick", tick, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_to_tick(n);
    chk("tick_after_reset", n, 11);
    wait_until(cyc + 60);
    chk("final_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_blinker_multi.md
Name: led_blinker_multi

Overview:
- Parametrised successor to the fixed one-second yellow-LED blinker.
- Drives NUM_CH LED outputs, each independently configured at run time through a simple write port.
- Per-channel modes: OFF, ON, continuous BLINK, and BURST (N blinks, then stop).
- Timing is derived from a shared 1 ms tick prescaled from the 12 MHz board clock. Sits at top level between control logic and the board LED pins.

Parameters:
- CLK_HZ, 12000000, input clock frequency in Hz.
- NUM_CH, 3, number of LED channels (1..8).
- LED_ACTIVE_LOW, 1, 1 = pin driven low to light the LED (board RGB LEDs).
- TICK_DIV, CLK_HZ/1000, clock cycles per 1 ms tick (derived, not overridden directly).

Ports:
- CLK  in  1  system clock, single clock domain.
- RST_N  in  1  asynchronous active-low reset.
- CFG_WE  in  1  configuration write strobe, one cycle.
- CFG_CH  in  3  target channel index.
- CFG_MODE  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
- CFG_HALF_MS  in  16  half-period in ms (on-time = off-time).
- CFG_COUNT  in  8  number of blinks for BURST.
- LED  out  NUM_CH  LED pin drive, registered.
- BUSY  out  NUM_CH  channel is in BLINK, or in BURST and not yet finished.
- TICK  out  1  1 ms tick strobe, exported for debug.

Behaviour:
- Reset: asserting RST_N low asynchronously clears the prescaler, all channel state, and BUSY to 0.
  - Every channel enters OFF; LED = {NUM_CH{LED_ACTIVE_LOW}} (all unlit).
  - The same holds for reset asserted mid-blink or mid-burst; nothing is retained.
- Prescaler: counter runs 0..TICK_DIV-1 and wraps.
  - TICK is high for exactly one cycle when the counter equals TICK_DIV-1.
  - Config writes never disturb the prescaler.
- Per-channel state: mode, half_ms, remaining, ms_cnt (16b), lit.
  - LED[i] = lit[i] XOR LED_ACTIVE_LOW, registered.
  - The LED output changes on the cycle after the state change.
- Config write: CFG_WE=1 with CFG_CH < NUM_CH loads the channel on that edge.
  - ms_cnt is set to 0.
  - OFF: lit=0, BUSY=0.
  - ON: lit=1, BUSY=0.
  - BLINK: lit=1, BUSY=1.
  - BURST: lit=1, BUSY=1, remaining=CFG_COUNT.
  - CFG_CH >= NUM_CH: the write is ignored and no state changes.
- CFG_HALF_MS = 0 is treated as 1.
- BURST with CFG_COUNT = 0: the channel goes straight to OFF with lit=0 and BUSY=0; BUSY never rises.
- Tick processing applies only in BLINK/BURST, on cycles where TICK=1 and no write targets that channel.
  - If ms_cnt == half_ms-1: ms_cnt=0 and lit toggles. Otherwise ms_cnt increments.
  - Because the prescaler is free-running, the first half-period lasts between half_ms-1 and half_ms ms. Every later half-period is exactly half_ms*TICK_DIV cycles.
- Burst completion: on each lit 1->0 toggle in BURST, remaining decrements.
  - When remaining reaches 0, the channel moves to OFF with lit=0, and BUSY drops on that same edge.
- Simultaneous write and TICK on the same channel: the write wins and the tick is discarded for that channel. Other channels still process the tick.
- Rewriting a channel while it is busy restarts it from the new configuration immediately; there is no queueing.
- Full 16-bit range is supported: half_ms = 65535 gives about 65.5 s. Counters must never overflow past half_ms-1.

Decomposition:
- Shared package/include `led_pkg`:
  - Mode encodings MODE_OFF / MODE_ON / MODE_BLINK / MODE_BURST.
  - Width constants HALF_W=16, COUNT_W=8.
- Sub-module `tick_gen` (params CLK_HZ, TICK_HZ=1000): outputs the one-cycle TICK strobe.
- Per-channel logic is built with a generate loop inside led_blinker_multi; there is no separate channel module.

Test Plan:
- All scenarios run with CLK_HZ=12000, so TICK_DIV=12.
- Reset: hold RST_N=0 for 5 cycles, then release. Expect LED=3'b111, BUSY=0, and TICK pulsing every 12 cycles thereafter.
- BLINK: write ch0, mode 2, half 3. Expect LED[0] low (lit) the cycle after the write.
  - It toggles after the 3rd TICK, then every 36 cycles.
  - BUSY[0] stays 1, and ch1/ch2 stay unlit.
- BURST: write ch1, mode 3, half 2, count 3. Expect exactly 3 lit pulses of 24 cycles each (the first may be 12..24).
  - BUSY[1] falls on the edge of the 3rd off-transition, and LED[1] stays high afterwards.
- Edge configs:
  - BURST with count 0: BUSY never rises and LED stays unlit.
  - half 0: behaves as half 1, toggling on every TICK.
  - Write with CFG_CH=5: no channel changes.
- Collision and restart:
  - Write ch0 on a TICK cycle: ms_cnt=0 and no toggle that cycle.
  - Rewrite ch1 to ON mid-burst: LED[1] lit and BUSY[1]=0 on the next cycle.
- Reset mid-burst: pull RST_N low during a burst. LED goes all-high and BUSY=0 without waiting for a clock edge, and the channel stays OFF after release.
